// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch port and a data port.
// Optional BUSY timeout is enabled by defining MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     if_request,
    input  logic [ADDRESS_WIDTH-1:0] if_address,
    output logic [DATA_WIDTH-1:0]    if_read_data,
    output logic                     if_ready,
    input  logic                     mem_request,
    input  logic                     mem_write,
    input  logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     mem_ready,
    output logic                     ram_request,
    output logic                     ram_write,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    input  logic [DATA_WIDTH-1:0]    ram_read_data,
    input  logic                     ram_ready,
    output logic                     grant_owner,
    output logic                     timeout_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_e;

    state_e                     state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_grant_q, last_grant_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic                       write_q, write_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
    logic                       grant_mem;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_q, timeout_d;
    logic             expired;

    assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // On a tie the data port wins unless it was the last one served.
    assign grant_mem = mem_request && (!if_request || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        count_d      = count_q;
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (if_request || mem_request) begin
                    state_d      = BUSY;
                    owner_d      = grant_mem;
                    last_grant_d = grant_mem;
                    addr_d       = grant_mem ? mem_address : if_address;
                    write_d      = grant_mem && mem_write;
                    wdata_d      = grant_mem ? mem_write_data : '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                    count_d      = '0;
`endif
                end
            end
            BUSY: begin
                if (ram_ready) begin
                    state_d = RESPOND;
                    if (!write_q) begin
                        if (owner_q) mem_rdata_d = ram_read_data;
                        else         if_rdata_d  = ram_read_data;
                    end
                end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                else if (expired) begin
                    state_d   = RESPOND;
                    timeout_d = 1'b1;
                    if (!write_q) begin
                        if (owner_q) mem_rdata_d = '0;
                        else         if_rdata_d  = '0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
`endif
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
            count_q      <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
            count_q      <= count_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state register, so reset clears them at once.
    assign ram_request    = (state_q == BUSY);
    assign ram_write      = (state_q == BUSY) && write_q;
    assign ram_address    = addr_q;
    assign ram_write_data = wdata_q;
    assign if_ready       = (state_q == RESPOND) && !owner_q;
    assign mem_ready      = (state_q == RESPOND) && owner_q;
    assign if_read_data   = if_rdata_q;
    assign mem_read_data  = mem_rdata_q;
    assign grant_owner    = owner_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    assign timeout_error  = timeout_q;
`else
    assign timeout_error  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin and memory-content model.
module tb_memory_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int unsigned MAX_DLY = 3;
`else
    localparam int unsigned MAX_DLY = 5;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          if_request, mem_request, mem_write, ram_ready;
    logic [AW-1:0] if_address, mem_address;
    logic [DW-1:0] mem_write_data, ram_read_data;
    logic [DW-1:0] if_read_data, mem_read_data, ram_write_data;
    logic [AW-1:0] ram_address;
    logic          if_ready, mem_ready, ram_request, ram_write, grant_owner, timeout_error;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    bit            last_mem;
    logic [DW-1:0] ram_model [logic [AW-1:0]];

    memory_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_request    (if_request),
        .if_address    (if_address),
        .if_read_data  (if_read_data),
        .if_ready      (if_ready),
        .mem_request   (mem_request),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_ready     (mem_ready),
        .ram_request   (ram_request),
        .ram_write     (ram_write),
        .ram_address   (ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data (ram_read_data),
        .ram_ready     (ram_ready),
        .grant_owner   (grant_owner),
        .timeout_error (timeout_error)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 15) << 2);
    endfunction

    task automatic clear_inputs();
        if_request = 0; if_address = '0; mem_request = 0; mem_write = 0;
        mem_address = '0; mem_write_data = '0; ram_ready = 0; ram_read_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        #1;
        tick();
        reset_n = 1;
        last_mem = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1;
        #1 reset_n = 0;
        #1;
        checks++; if (ram_request !== 1'b0) begin errors++; $display("FAIL reset_ram_request: got %b expected 0", ram_request); end
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL reset_ram_write: got %b expected 0", ram_write); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b expected 0", if_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
        checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL reset_grant_owner: got %b expected 0", grant_owner); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_timeout_error: got %b expected 0", timeout_error); end
        checks++; if (if_read_data !== '0) begin errors++; $display("FAIL reset_if_read_data: got %h expected 0", if_read_data); end
        checks++; if (mem_read_data !== '0) begin errors++; $display("FAIL reset_mem_read_data: got %h expected 0", mem_read_data); end
        checks++; if (ram_address !== '0) begin errors++; $display("FAIL reset_ram_address: got %h expected 0", ram_address); end
        checks++; if (ram_write_data !== '0) begin errors++; $display("FAIL reset_ram_write_data: got %h expected 0", ram_write_data); end
        tick();
        reset_n = 1;
        last_mem = 0;
    endtask

    task automatic test_fetch_single();
        do_reset();
        if_request = 1; if_address = 'h40; ram_ready = 1; ram_read_data = 'h1234_5678;
        tick();
        checks++; if (ram_request !== 1'b1) begin errors++; $display("FAIL fetch_ram_request: got %b expected 1", ram_request); end
        checks++; if (ram_address !== AW'('h40)) begin errors++; $display("FAIL fetch_ram_address: got %h expected 40", ram_address); end
        checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL fetch_grant_owner: got %b expected 0", grant_owner); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_early_ready: got %b expected 0", if_ready); end
        tick();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_if_ready: got %b expected 1", if_ready); end
        checks++; if (if_read_data !== DW'('h1234_5678)) begin errors++; $display("FAIL fetch_if_read_data: got %h expected 12345678", if_read_data); end
        checks++; if (ram_request !== 1'b0) begin errors++; $display("FAIL fetch_respond_ram_request: got %b expected 0", ram_request); end
        ram_ready = 0;
        tick();
        if_request = 0;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b expected 0", if_ready); end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        if_request = 1; if_address = 'h100;
        mem_request = 1; mem_write = 1; mem_address = 'h80; mem_write_data = 'hDEAD_BEEF;
        tick();
        checks++; if (grant_owner !== 1'b1) begin errors++; $display("FAIL tie_first_owner: got %b expected 1", grant_owner); end
        checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL tie_ram_write: got %b expected 1", ram_write); end
        checks++; if (ram_address !== AW'('h80)) begin errors++; $display("FAIL tie_ram_address: got %h expected 80", ram_address); end
        checks++; if (ram_write_data !== DW'('hDEAD_BEEF)) begin errors++; $display("FAIL tie_ram_write_data: got %h expected deadbeef", ram_write_data); end
        ram_ready = 1; ram_read_data = 'hCAFE_F00D;
        tick();
        ram_ready = 0;
        checks++; if (mem_ready !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL tie_store_ready: got mem=%b if=%b expected mem=1 if=0", mem_ready, if_ready); end
        checks++; if (mem_read_data !== '0) begin errors++; $display("FAIL tie_store_read_data: got %h expected 0", mem_read_data); end
        tick();
        mem_request = 0; mem_write = 0;
        ram_ready = 1; ram_read_data = 'h55AA_33CC;
        tick();
        checks++; if (grant_owner !== 1'b0 || ram_write !== 1'b0) begin errors++; $display("FAIL tie_second_owner: got owner=%b write=%b expected 0 0", grant_owner, ram_write); end
        checks++; if (ram_address !== AW'('h100)) begin errors++; $display("FAIL tie_second_address: got %h expected 100", ram_address); end
        tick();
        ram_ready = 0;
        checks++; if (if_ready !== 1'b1 || if_read_data !== DW'('h55AA_33CC)) begin errors++; $display("FAIL tie_fetch_done: got ready=%b data=%h expected 1 55aa33cc", if_ready, if_read_data); end
        checks++; if (mem_read_data !== '0) begin errors++; $display("FAIL tie_mem_read_kept: got %h expected 0", mem_read_data); end
        tick();
        if_request = 0;
    endtask

    task automatic test_slow_memory();
        do_reset();
        mem_request = 1; mem_write = 0; mem_address = 'h24;
        tick();
        for (int unsigned i = 0; i <= MAX_DLY; i++) begin
            checks++; if (ram_request !== 1'b1 || ram_address !== AW'('h24)) begin errors++; $display("FAIL slow_stable[%0d]: got req=%b addr=%h expected 1 24", i, ram_request, ram_address); end
            checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL slow_early_ready[%0d]: got %b expected 0", i, mem_ready); end
            ram_ready = (i == MAX_DLY);
            ram_read_data = (i == MAX_DLY) ? DW'('h0BAD_F00D) : DW'($urandom);
            tick();
        end
        ram_ready = 0;
        checks++; if (mem_ready !== 1'b1 || mem_read_data !== DW'('h0BAD_F00D)) begin errors++; $display("FAIL slow_done: got ready=%b data=%h expected 1 0badf00d", mem_ready, mem_read_data); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL slow_timeout_error: got %b expected 0", timeout_error); end
        tick();
        mem_request = 0;
        checks++; if (mem_ready !== 1'b0 || ram_request !== 1'b0) begin errors++; $display("FAIL slow_pulse_width: got ready=%b req=%b expected 0 0", mem_ready, ram_request); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        if_request = 1; if_address = 'h60;
        tick();
        checks++; if (ram_request !== 1'b1) begin errors++; $display("FAIL rstbusy_request: got %b expected 1", ram_request); end
        #2 reset_n = 0;
        #1;
        checks++; if (ram_request !== 1'b0) begin errors++; $display("FAIL rstbusy_async_drop: got %b expected 0", ram_request); end
        if_request = 0;
        tick();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rstbusy_no_ready_in_reset: got %b expected 0", if_ready); end
        reset_n = 1;
        last_mem = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_ready !== 1'b0 || ram_request !== 1'b0) begin errors++; $display("FAIL rstbusy_idle[%0d]: got ready=%b req=%b expected 0 0", i, if_ready, ram_request); end
        end
    endtask

    task automatic test_traffic(input int unsigned n_txn, input bit saturate);
        bit            fa, ma, mw, exp_owner, prev_owner, seq_ok, blk_if, blk_mem;
        logic [AW-1:0] fadr, madr, a;
        logic [DW-1:0] mwd, rd, exp_if_rd, exp_mem_rd;
        int unsigned   dly, n_mem, n_if;
        do_reset();
        fa = 0; ma = 0; mw = 0; fadr = '0; madr = '0; mwd = '0; exp_if_rd = '0; exp_mem_rd = '0;
        n_mem = 0; n_if = 0; seq_ok = 1; prev_owner = 0; blk_if = 0; blk_mem = 0;
        for (int unsigned t = 0; t < n_txn; t++) begin
            if (!saturate && !fa && !ma && $urandom_range(0, 1) == 1) begin
                tick();
                checks++; if (ram_request !== 1'b0) begin errors++; $display("FAIL traffic_idle_gap[%0d]: got %b expected 0", t, ram_request); end
                blk_if = 0; blk_mem = 0;
            end
            if (!fa && !blk_if && (saturate || $urandom_range(0, 1) == 1)) begin fa = 1; fadr = rand_addr(); end
            if (!ma && !blk_mem && (saturate || $urandom_range(0, 1) == 1)) begin
                ma = 1; madr = rand_addr(); mw = ($urandom_range(0, 1) == 1); mwd = DW'($urandom);
            end
            if (!fa && !ma) begin
                if (blk_if) begin ma = 1; madr = rand_addr(); mw = ($urandom_range(0, 1) == 1); mwd = DW'($urandom); end
                else begin fa = 1; fadr = rand_addr(); end
            end
            blk_if = 0; blk_mem = 0;
            if_request = fa; if_address = fadr;
            mem_request = ma; mem_address = madr; mem_write = mw; mem_write_data = mwd;
            exp_owner = (fa && ma) ? !last_mem : ma;
            last_mem = exp_owner;
            tick();
            a = exp_owner ? madr : fadr;
            checks++; if (grant_owner !== exp_owner || ram_request !== 1'b1) begin errors++; $display("FAIL traffic_grant[%0d]: got owner=%b req=%b expected %b 1", t, grant_owner, ram_request, exp_owner); end
            checks++; if (ram_address !== a || ram_write !== (exp_owner && mw)) begin errors++; $display("FAIL traffic_ram_cmd[%0d]: got addr=%h wr=%b expected %h %b", t, ram_address, ram_write, a, exp_owner && mw); end
            if (exp_owner && mw) begin
                checks++; if (ram_write_data !== mwd) begin errors++; $display("FAIL traffic_wdata[%0d]: got %h expected %h", t, ram_write_data, mwd); end
                ram_model[a] = mwd;
                rd = DW'($urandom);
            end else begin
                if (!ram_model.exists(a)) ram_model[a] = DW'($urandom);
                rd = ram_model[a];
            end
            if (!exp_owner) exp_if_rd = rd;
            else if (!mw) exp_mem_rd = rd;
            if (exp_owner && !fa && (saturate || $urandom_range(0, 1) == 1)) begin
                fa = 1; fadr = rand_addr(); if_request = 1; if_address = fadr;
            end
            if (!exp_owner && !ma && (saturate || $urandom_range(0, 1) == 1)) begin
                ma = 1; madr = rand_addr(); mw = ($urandom_range(0, 1) == 1); mwd = DW'($urandom);
                mem_request = 1; mem_address = madr; mem_write = mw; mem_write_data = mwd;
            end
            dly = $urandom_range(0, MAX_DLY);
            for (int unsigned d = 0; d <= dly; d++) begin
                if (d > 0) begin
                    checks++; if (ram_request !== 1'b1 || ram_address !== a || (if_ready | mem_ready) !== 1'b0) begin errors++; $display("FAIL traffic_busy_stable[%0d]: got req=%b addr=%h rdy=%b%b expected 1 %h 00", t, ram_request, ram_address, if_ready, mem_ready, a); end
                end
                ram_ready = (d == dly);
                ram_read_data = (d == dly) ? rd : DW'($urandom);
                tick();
            end
            ram_ready = 0;
            checks++; if (if_ready !== !exp_owner || mem_ready !== exp_owner) begin errors++; $display("FAIL traffic_ready[%0d]: got if=%b mem=%b expected owner=%b", t, if_ready, mem_ready, exp_owner); end
            checks++; if (if_read_data !== exp_if_rd || mem_read_data !== exp_mem_rd) begin errors++; $display("FAIL traffic_rdata[%0d]: got if=%h mem=%h expected %h %h", t, if_read_data, mem_read_data, exp_if_rd, exp_mem_rd); end
            checks++; if (ram_request !== 1'b0 || ram_write !== 1'b0 || timeout_error !== 1'b0) begin errors++; $display("FAIL traffic_respond_outputs[%0d]: got req=%b wr=%b tmo=%b expected 0 0 0", t, ram_request, ram_write, timeout_error); end
            if ((t == 0 && !exp_owner) || (t > 0 && exp_owner == prev_owner)) seq_ok = 0;
            prev_owner = exp_owner;
            if (exp_owner) n_mem++; else n_if++;
            tick();
            if (exp_owner) begin ma = 0; mem_request = 0; blk_mem = 1; end
            else begin fa = 0; if_request = 0; blk_if = 1; end
            checks++; if ((if_ready | mem_ready | ram_request) !== 1'b0) begin errors++; $display("FAIL traffic_idle[%0d]: got if=%b mem=%b req=%b expected 0 0 0", t, if_ready, mem_ready, ram_request); end
        end
        if (saturate) begin
            checks++; if (seq_ok !== 1'b1) begin errors++; $display("FAIL rr_alternation: got %b expected 1", seq_ok); end
            checks++; if (n_mem != n_txn / 2 || n_if != n_txn / 2) begin errors++; $display("FAIL rr_counts: got mem=%0d if=%0d expected %0d each", n_mem, n_if, n_txn / 2); end
        end
        clear_inputs();
    endtask

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        if_request = 1; if_address = 'h10; ram_ready = 1; ram_read_data = 'hA5A5_A5A5;
        tick();
        tick();
        ram_ready = 0;
        checks++; if (if_ready !== 1'b1 || if_read_data !== DW'('hA5A5_A5A5)) begin errors++; $display("FAIL tmo_prefetch: got ready=%b data=%h expected 1 a5a5a5a5", if_ready, if_read_data); end
        tick();
        if_address = 'h14;
        tick();
        for (int unsigned i = 0; i < 4; i++) begin
            checks++; if (ram_request !== 1'b1 || if_ready !== 1'b0 || timeout_error !== 1'b0) begin errors++; $display("FAIL tmo_busy[%0d]: got req=%b rdy=%b tmo=%b expected 1 0 0", i, ram_request, if_ready, timeout_error); end
            tick();
        end
        checks++; if (if_ready !== 1'b1 || if_read_data !== '0) begin errors++; $display("FAIL tmo_respond: got ready=%b data=%h expected 1 0", if_ready, if_read_data); end
        checks++; if (timeout_error !== 1'b1 || ram_request !== 1'b0) begin errors++; $display("FAIL tmo_flag: got tmo=%b req=%b expected 1 0", timeout_error, ram_request); end
        tick();
        if_request = 0;
        mem_request = 1; mem_address = 'h18; ram_ready = 1; ram_read_data = 'h1111_2222;
        tick();
        tick();
        ram_ready = 0;
        checks++; if (mem_ready !== 1'b1 || timeout_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got rdy=%b tmo=%b expected 1 1", mem_ready, timeout_error); end
        tick();
        mem_request = 0;
        reset_n = 0;
        #1;
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL tmo_reset_clear: got %b expected 0", timeout_error); end
        tick();
        reset_n = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_single();
        test_tie_after_reset();
        test_slow_memory();
        test_reset_mid_busy();
        test_traffic(40, 1'b0);
        test_traffic(8, 1'b1);
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, 32: width of every address bus.
REQ-002 Parameter DATA_WIDTH, 32: width of every data bus.
REQ-003 Parameter TIMEOUT_CYCLES, 255: BUSY-cycle limit, used only when the Configuration macro is defined.
REQ-004 Port clock  in  1: single clock; all state changes on its rising edge.
REQ-005 Port reset_n  in  1: asynchronous, active-low reset.
REQ-006 Fetch-port signals:
- if_request  in  1: fetch request.
- if_address  in  ADDRESS_WIDTH: fetch address.
- if_read_data  out  DATA_WIDTH: fetched word (registered).
- if_ready  out  1: one-cycle completion pulse.
REQ-007 Data-port signals:
- mem_request  in  1: data request.
- mem_write  in  1: 1 = store, 0 = load.
- mem_address  in  ADDRESS_WIDTH: data address.
- mem_write_data  in  DATA_WIDTH: store value.
- mem_read_data  out  DATA_WIDTH: load value (registered).
- mem_ready  out  1: one-cycle completion pulse.
REQ-008 Shared-memory-side signals:
- ram_request  out  1: memory request.
- ram_write  out  1: write enable.
- ram_address  out  ADDRESS_WIDTH: memory address.
- ram_write_data  out  DATA_WIDTH: memory write data.
- ram_read_data  in  DATA_WIDTH: memory read data.
- ram_ready  in  1: memory completion.
REQ-009 Status signals:
- grant_owner  out  1: 0 = fetch, 1 = data; owner of the current or last transaction.
- timeout_error  out  1: sticky timeout flag.

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY and RESPOND.
REQ-011 Request handshake: each requester SHALL hold its request and request fields stable until its ready pulse, and SHALL drop the request the cycle after that pulse.
REQ-012 In IDLE with exactly one request high, the arbiter SHALL grant that requester and enter BUSY on the next edge.
REQ-013 In IDLE with both requests high, the arbiter SHALL grant the port not served last (round-robin on last_grant), so neither port is starved.
REQ-014 On a grant, the arbiter SHALL register the owner's address, write flag (fetch always 0) and write data, and SHALL update grant_owner and last_grant.
REQ-015 In BUSY, ram_request SHALL be 1 and ram_address/ram_write/ram_write_data SHALL carry the registered values, stable for the whole state.
REQ-016 In BUSY with ram_ready=1, the arbiter SHALL:
- capture ram_read_data into the owner's read_data register, reads only (writes leave mem_read_data unchanged);
- enter RESPOND.
REQ-017 In RESPOND, the owner's ready SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE, ignoring all requests during RESPOND.
REQ-018 Minimum latency: request sampled in IDLE at cycle n, ram_request at n+1, ready at n+2 when ram_ready is 1 at n+1; the arbiter SHALL accept a new grant at n+3.
REQ-019 The non-owner's ready SHALL remain 0 and its read_data SHALL remain unchanged throughout another port's transaction.
REQ-020 The arbiter SHALL drive ram_request, ram_write, if_ready and mem_ready to 0 in IDLE and RESPOND.
REQ-021 A request arriving while BUSY or in RESPOND SHALL wait, with no loss, until the next IDLE.

Reset
REQ-022 With reset_n=0, the arbiter SHALL immediately and asynchronously set:
- state to IDLE;
- ram_request, ram_write, if_ready, mem_ready, grant_owner and timeout_error to 0;
- all data/address registers to 0;
- last_grant to fetch, so that the first tie goes to the data port.
REQ-023 A reset during BUSY SHALL abort the transaction with no ready pulse; the requester re-issues after reset.

Configuration
REQ-024 Macro MEMORY_ARBITER_TIMEOUT_EN, when defined, SHALL enable a BUSY-cycle counter, cleared on entry to BUSY.
REQ-025 With the macro defined, if the counter reaches TIMEOUT_CYCLES without ram_ready, the arbiter SHALL:
- drop ram_request;
- load 0 into the owner's read_data (on reads);
- enter RESPOND, pulsing the owner's ready;
- set timeout_error, which stays set until reset.
REQ-026 Without the macro, BUSY SHALL wait indefinitely for ram_ready, timeout_error SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-027 Fetch only, if_address=0x40, ram_ready at first BUSY cycle with ram_read_data=0x12345678 -> if_ready pulses at cycle n+2 with if_read_data=0x12345678, grant_owner=0.
REQ-028 Both ports request in the same cycle after reset (mem_write=1, address 0x80, data 0xDEADBEEF) -> the data store is served first (ram_write=1, ram_address=0x80), then the fetch; mem_read_data is unchanged.
REQ-029 Both ports hold continuous requests for 8 transactions -> grants alternate data, fetch, data, fetch..., with 4 of each.
REQ-030 ram_ready delayed 5 cycles -> ram_request and ram_address are stable for all 5 BUSY cycles, and the ready pulse is exactly 1 cycle wide.
REQ-031 reset_n=0 asserted mid-BUSY -> ram_request falls without waiting for a clock edge, no ready pulse occurs, and the state is IDLE after release.
REQ-032 With MEMORY_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and ram_ready held 0 -> after 4 BUSY cycles the owner's ready pulses with read_data=0 and timeout_error=1, which stays set until reset.
